// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch bus.
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : word-aligned fetch address, stable while imem_req=1
//   imem_ack   : memory returns imem_rdata this cycle
//   imem_rdata : fetched 32-bit instruction word
// The master modport belongs to the fetch unit; the slave modport belongs to the memory.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage of the RV64 pipeline.
// This block owns the architectural PC and issues word fetches over a req/ack bus.
// It feeds the IF/ID buffer with the fetched instruction, its PC, a load enable
// and a clear signal. It tolerates variable memory latency, hazard stalls and
// branch/jump redirects.
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   stall        : IF/ID must hold its contents this cycle
//   redirect     : taken branch/jump resolved downstream; redirect_pc is the target
//   imem         : fetch bus (master side)
//   nextInstruc  : instruction presented to IF/ID
//   nextPC       : PC of nextInstruc
//   e_write      : IF/ID load enable
//   IF_flush     : IF/ID clear
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [63:0]            redirect_pc,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            nextInstruc,
  output logic [63:0]            nextPC,
  output logic                   e_write,
  output logic                   IF_flush
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] inst_q, inst_d;

  logic        req_c;
  logic [63:0] target;
  logic [63:0] pc_inc;

  assign target = {redirect_pc[63:2], 2'b00};
  assign pc_inc = pc_q + 64'd4;  // wraps modulo 2^64

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      inst_q       <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      inst_q       <= inst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    inst_d       = inst_q;
    req_c        = 1'b0;
    e_write      = 1'b0;
    nextInstruc  = inst_q;
    nextPC       = pc_q;

    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d         = target;
          fetch_addr_d = target;
        end else begin
          fetch_addr_d = pc_q;
        end
        state_d = REQ;
      end

      REQ: begin
        req_c = 1'b1;
        if (redirect) begin
          pc_d = target;
          if (imem.imem_ack) begin
            // The returned word belongs to the wrong path, so it is dropped.
            // The target fetch starts on the next cycle.
            fetch_addr_d = target;
          end else begin
            // The pending fetch cannot be withdrawn. It must still complete,
            // and its data is discarded in DROP.
            state_d = DROP;
          end
        end else if (imem.imem_ack) begin
          if (stall) begin
            inst_d  = imem.imem_rdata;
            state_d = HOLD;
          end else begin
            e_write      = 1'b1;
            nextInstruc  = imem.imem_rdata;
            pc_d         = pc_inc;
            fetch_addr_d = pc_inc;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d         = target;
          fetch_addr_d = target;
          state_d      = REQ;
        end else if (!stall) begin
          e_write      = 1'b1;
          pc_d         = pc_inc;
          fetch_addr_d = pc_inc;
          state_d      = REQ;
        end
      end

      DROP: begin
        req_c = 1'b1;
        if (redirect) pc_d = target;
        if (imem.imem_ack) begin
          // Use the newest target, including one that arrives on this same cycle.
          fetch_addr_d = pc_d;
          state_d      = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Gating with rst_n keeps the clear low while reset is held, whatever redirect does.
  assign IF_flush       = redirect & rst_n;
  assign imem.imem_req  = req_c;
  assign imem.imem_addr = fetch_addr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  localparam logic [63:0] RST_PC = 64'h1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect;
  logic [63:0] redirect_pc;
  logic [31:0] nextInstruc;
  logic [63:0] nextPC;
  logic        e_write, IF_flush;

  always #5 clk = ~clk;

  if_fetch_unit_if bus();

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .nextInstruc (nextInstruc),
    .nextPC      (nextPC),
    .e_write     (e_write),
    .IF_flush    (IF_flush)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the program-order stream of PCs expected to reach IF/ID.
  logic [63:0] exp_q[$];
  logic [63:0] model_next;

  // Memory model state.
  int   mem_cnt, cur_lat, lat_fixed, lat_max;
  bit   lat_rand;
  logic last_req, last_ack;

  // Monitor state.
  bit          mon_en;
  int          ew_count;
  logic        prev_pending;
  logic [63:0] prev_addr;
  logic [63:0] mon_exp;

  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 4) begin
      exp_q.push_back(model_next);
      model_next = model_next + 64'd4;
    end
  endtask

  task automatic model_restart(input logic [63:0] pc);
    exp_q.delete();
    model_next = {pc[63:2], 2'b00};
    topup();
  endtask

  // One clock cycle: drive the control inputs and the memory response 1 time unit after the edge.
  task automatic step(input logic s, input logic r, input logic [63:0] rpc);
    @(posedge clk);
    if (!last_req || last_ack) mem_cnt = 0;
    else mem_cnt++;
    #1;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    if (r) model_restart(rpc);
    else topup();
    if (bus.imem_req) begin
      if (mem_cnt == 0) cur_lat = lat_rand ? int'($urandom_range(lat_max, 0)) : lat_fixed;
      bus.imem_ack   = (mem_cnt >= cur_lat);
      bus.imem_rdata = memf(bus.imem_addr);
    end else begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'hDEAD_BEEF;
    end
    last_req = bus.imem_req;
    last_ack = bus.imem_ack;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   bus.imem_req,  1'b0);
    chk({tag, "_addr"},  bus.imem_addr, RST_PC);
    chk({tag, "_ewr"},   e_write,       1'b0);
    chk({tag, "_flush"}, IF_flush,      1'b0);
    chk({tag, "_npc"},   nextPC,        RST_PC);
    chk({tag, "_ninst"}, nextInstruc,   32'h0);
  endtask

  // Monitor: cycle-level rules plus the scoreboard pop on each IF/ID write.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pending = 1'b0;
    end else if (mon_en) begin
      if (redirect) begin
        chk("flush_on_redirect", IF_flush, 1'b1);
        chk("no_write_on_redirect", e_write, 1'b0);
      end else begin
        chk("no_spurious_flush", IF_flush, 1'b0);
      end
      if (stall) chk("no_write_on_stall", e_write, 1'b0);
      if (prev_pending) begin
        chk("req_held_until_ack", bus.imem_req, 1'b1);
        chk("addr_stable", bus.imem_addr, prev_addr);
      end
      if (e_write) begin
        ew_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write got nextPC %h expected no write", nextPC);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("nextPC", nextPC, mon_exp);
          chk("nextInstruc", nextInstruc, memf(mon_exp));
        end
      end
      prev_pending = bus.imem_req && !bus.imem_ack;
      prev_addr    = bus.imem_addr;
    end
  end

  logic [63:0] hold_pc;
  bit          found;

  initial begin
    rst_n = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    lat_rand = 0; lat_fixed = 0; lat_max = 3;
    last_req = 0; last_ack = 0; mem_cnt = 0; cur_lat = 0;
    mon_en = 0; ew_count = 0; prev_pending = 0; prev_addr = '0;
    #1 rst_n = 1'b0;
    #2 chk_reset_outputs("reset");
    model_restart(RST_PC);
    @(posedge clk); #1 rst_n = 1'b1; mon_en = 1;

    // Zero-wait memory: consecutive addresses and one write per cycle.
    step(0, 0, '0); #1;
    chk("first_req", bus.imem_req, 1'b1);
    chk("first_addr", bus.imem_addr, RST_PC);
    chk("first_ewr", e_write, 1'b1);
    step(0, 0, '0); #1;
    chk("addr_1004", bus.imem_addr, RST_PC + 64'd4);
    chk("npc_1004", nextPC, RST_PC + 64'd4);
    step(0, 0, '0); #1;
    chk("addr_1008", bus.imem_addr, RST_PC + 64'd8);
    ew_count = 0;
    repeat (8) step(0, 0, '0);
    chk("zero_wait_rate", ew_count, 8);

    // Three-cycle latency: exactly one write every four cycles.
    lat_fixed = 3;
    repeat (8) step(0, 0, '0);
    ew_count = 0;
    repeat (40) step(0, 0, '0);
    chk("lat3_rate", ew_count, 10);

    // Stall on the ack cycle, held for three cycles, then released.
    lat_fixed = 0;
    step(0, 0, '0);
    step(1, 0, '0); #1;
    hold_pc = exp_q[0];
    chk("stall_ack_ewr", e_write, 1'b0);
    repeat (2) begin
      step(1, 0, '0); #1;
      chk("hold_req_low", bus.imem_req, 1'b0);
      chk("hold_ewr", e_write, 1'b0);
    end
    step(0, 0, '0); #1;
    chk("release_ewr", e_write, 1'b1);
    chk("release_npc", nextPC, hold_pc);
    step(0, 0, '0); #1;
    chk("after_release_req", bus.imem_req, 1'b1);
    chk("after_release_addr", bus.imem_addr, hold_pc + 64'd4);

    // Redirect to an unaligned target while a fetch is pending.
    lat_fixed = 3;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(0, 0, '0); #1;
      if (bus.imem_req && !bus.imem_ack) found = 1;
    end
    chk("pending_found", found, 1'b1);
    step(0, 1, 64'h2003); #1;
    chk("redir_flush", IF_flush, 1'b1);
    chk("redir_ewr", e_write, 1'b0);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(0, 0, '0); #1;
      if (bus.imem_req && bus.imem_addr == 64'h2000) found = 1;
    end
    chk("redir_target_fetch", found, 1'b1);
    repeat (8) step(0, 0, '0);

    // Redirect together with stall while in HOLD.
    lat_fixed = 0;
    repeat (3) step(0, 0, '0);
    step(1, 0, '0);
    step(1, 0, '0); #1;
    chk("hold2_req_low", bus.imem_req, 1'b0);
    step(1, 1, 64'h3000); #1;
    chk("hold_redir_flush", IF_flush, 1'b1);
    chk("hold_redir_ewr", e_write, 1'b0);
    step(0, 0, '0); #1;
    chk("hold_redir_req", bus.imem_req, 1'b1);
    chk("hold_redir_addr", bus.imem_addr, 64'h3000);
    repeat (4) step(0, 0, '0);

    // PC wrap-around at the top of the address space.
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFF8);
    ew_count = 0;
    repeat (8) step(0, 0, '0);
    chk("wrap_progress", ew_count >= 4, 1'b1);

    // Randomised traffic: random latency, stalls and redirects.
    lat_rand = 1;
    ew_count = 0;
    repeat (2000) step($urandom_range(9, 0) < 2, $urandom_range(19, 0) == 0, {$urandom, $urandom});
    chk("random_progress", ew_count >= 200, 1'b1);
    lat_rand = 0;
    repeat (2) step(0, 0, '0);

    // Asynchronous reset while a fetch is waiting on memory.
    lat_fixed = 3;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(0, 0, '0); #1;
      if (bus.imem_req && !bus.imem_ack) found = 1;
    end
    chk("pending_before_reset", found, 1'b1);
    rst_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; bus.imem_ack = 1'b0;
    #1 chk_reset_outputs("midreset");
    last_req = 0; last_ack = 0;
    model_restart(RST_PC);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lat_fixed = 0;
    step(0, 0, '0); #1;
    chk("restart_req", bus.imem_req, 1'b1);
    chk("restart_addr", bus.imem_addr, RST_PC);
    chk("restart_npc", nextPC, RST_PC);
    repeat (6) step(0, 0, '0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
